// File: rtl/dcache_wbuf_pkg.sv
// Shared types and constants for the data-cache write buffer.
package dcache_wbuf_pkg;

  localparam logic [2:0] WR_TYPE_WORD     = 3'b010;
  localparam logic [2:0] WR_TYPE_LINE     = 3'b100;
  localparam int         LINE_OFFSET_BITS = 4;
  localparam int         TAG_W            = 32 - LINE_OFFSET_BITS;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_DONE  = 2'b10
  } wbuf_state_e;

  typedef struct packed {
    logic [2:0]   wr_type;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/dcache_wbuf_fifo.sv
// Circular write-entry store with extended pointers; exposes per-slot line tags
// so the parent can detect read-after-write hazards.
module wbuf_fifo
  import dcache_wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enq,
  input  wbuf_entry_t                 enq_entry,
  input  logic                        deq,
  output wbuf_entry_t                 head_entry,
  output logic [DEPTH-1:0]            slot_valid,
  output logic [DEPTH-1:0][TAG_W-1:0] slot_tag,
  output logic                        full,
  output logic                        empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] count_s;
  logic [IDX_W-1:0] off_s;
  logic             enq_ok_s;
  logic             deq_ok_s;
  wbuf_entry_t      mem_r [DEPTH];

  assign full       = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                      (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
  assign empty      = (wr_ptr_r == rd_ptr_r);
  assign enq_ok_s   = enq && !full;
  assign deq_ok_s   = deq && !empty;
  assign count_s    = wr_ptr_r - rd_ptr_r;
  assign head_entry = mem_r[rd_ptr_r[IDX_W-1:0]];

  // A slot is live when its distance from the read index is below the occupancy.
  always_comb begin
    off_s      = '0;
    slot_valid = '0;
    slot_tag   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s         = IDX_W'(i) - rd_ptr_r[IDX_W-1:0];
      slot_valid[i] = ({1'b0, off_s} < count_s);
      slot_tag[i]   = mem_r[i].addr[31:LINE_OFFSET_BITS];
    end
  end

  // Entry payload write; payload is not reset, only the pointers qualify it.
  always_ff @(posedge clk) begin
    if (enq_ok_s) begin
      mem_r[wr_ptr_r[IDX_W-1:0]] <= enq_entry;
    end
  end

  // Pointer update, wrapping with MSB toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (enq_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (deq_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
    end
  end

endmodule

// File: rtl/dcache_wbuf.sv
// Data-cache write buffer: queues dcache writes toward the bridge, stalls reads
// that hit a buffered line, and supports a drain-all flush handshake.
module dcache_wbuf
  import dcache_wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cache_wr_req,
  input  logic [2:0]   cache_wr_type,
  input  logic [31:0]  cache_wr_addr,
  input  logic [3:0]   cache_wr_wstrb,
  input  logic [127:0] cache_wr_data,
  output logic         cache_wr_rdy,
  input  logic         cache_rd_req,
  input  logic [2:0]   cache_rd_type,
  input  logic [31:0]  cache_rd_addr,
  output logic         cache_rd_rdy,
  output logic         mem_wr_req,
  output logic [2:0]   mem_wr_type,
  output logic [31:0]  mem_wr_addr,
  output logic [3:0]   mem_wr_wstrb,
  output logic [127:0] mem_wr_data,
  input  logic         mem_wr_rdy,
  output logic         mem_rd_req,
  output logic [2:0]   mem_rd_type,
  output logic [31:0]  mem_rd_addr,
  input  logic         mem_rd_rdy,
  input  logic         flush_req,
  output logic         flush_done,
  output logic         wbuf_empty
);

  wbuf_state_e                 state_r;
  wbuf_state_e                 state_nxt_s;
  wbuf_entry_t                 enq_entry_s;
  wbuf_entry_t                 head_s;
  logic                        enq_s;
  logic                        deq_s;
  logic                        full_s;
  logic                        empty_s;
  logic                        conflict_s;
  logic [DEPTH-1:0]            slot_valid_s;
  logic [DEPTH-1:0][TAG_W-1:0] slot_tag_s;

  assign cache_wr_rdy = !full_s && (state_r == ST_RUN);
  assign enq_s        = cache_wr_req && cache_wr_rdy;
  assign deq_s        = mem_wr_req && mem_wr_rdy;
  assign enq_entry_s  = '{wr_type: cache_wr_type, addr: cache_wr_addr,
                          wstrb: cache_wr_wstrb, data: cache_wr_data};

  wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .enq        (enq_s),
    .enq_entry  (enq_entry_s),
    .deq        (deq_s),
    .head_entry (head_s),
    .slot_valid (slot_valid_s),
    .slot_tag   (slot_tag_s),
    .full       (full_s),
    .empty      (empty_s)
  );

  assign mem_wr_req   = !empty_s;
  assign mem_wr_type  = head_s.wr_type;
  assign mem_wr_addr  = head_s.addr;
  assign mem_wr_wstrb = head_s.wstrb;
  assign mem_wr_data  = head_s.data;
  assign wbuf_empty   = empty_s;
  assign flush_done   = (state_r == ST_DONE);

  // A read conflicts with any live entry, or the entry entering this cycle, on the same line.
  always_comb begin
    conflict_s = enq_s &&
                 (cache_wr_addr[31:LINE_OFFSET_BITS] == cache_rd_addr[31:LINE_OFFSET_BITS]);
    for (int i = 0; i < DEPTH; i++) begin
      conflict_s = conflict_s ||
                   (slot_valid_s[i] && (slot_tag_s[i] == cache_rd_addr[31:LINE_OFFSET_BITS]));
    end
  end

  assign mem_rd_req   = cache_rd_req && !conflict_s;
  assign cache_rd_rdy = mem_rd_rdy && !conflict_s;
  assign mem_rd_type  = cache_rd_type;
  assign mem_rd_addr  = cache_rd_addr;

  // Flush sequencing next-state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (flush_req) state_nxt_s = ST_FLUSH;
        else           state_nxt_s = ST_RUN;
      end
      ST_FLUSH: begin
        if (empty_s && !enq_s) state_nxt_s = ST_DONE;
        else                   state_nxt_s = ST_FLUSH;
      end
      ST_DONE: state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Flush state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

endmodule

// File: tb/tb_dcache_wbuf.sv
// Randomized and directed bench for dcache_wbuf against a queue-based reference
// model; a negedge monitor checks per-cycle outputs and write ordering.
module tb_dcache_wbuf;
  import dcache_wbuf_pkg::*;

  localparam int DEPTH = 4;
  localparam int M_RUN = 0;
  localparam int M_FLUSH = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         cache_wr_req;
  logic [2:0]   cache_wr_type;
  logic [31:0]  cache_wr_addr;
  logic [3:0]   cache_wr_wstrb;
  logic [127:0] cache_wr_data;
  logic         cache_wr_rdy;
  logic         cache_rd_req;
  logic [2:0]   cache_rd_type;
  logic [31:0]  cache_rd_addr;
  logic         cache_rd_rdy;
  logic         mem_wr_req;
  logic [2:0]   mem_wr_type;
  logic [31:0]  mem_wr_addr;
  logic [3:0]   mem_wr_wstrb;
  logic [127:0] mem_wr_data;
  logic         mem_wr_rdy;
  logic         mem_rd_req;
  logic [2:0]   mem_rd_type;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_rdy;
  logic         flush_req;
  logic         flush_done;
  logic         wbuf_empty;

  dcache_wbuf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cache_wr_req(cache_wr_req), .cache_wr_type(cache_wr_type),
    .cache_wr_addr(cache_wr_addr), .cache_wr_wstrb(cache_wr_wstrb),
    .cache_wr_data(cache_wr_data), .cache_wr_rdy(cache_wr_rdy),
    .cache_rd_req(cache_rd_req), .cache_rd_type(cache_rd_type),
    .cache_rd_addr(cache_rd_addr), .cache_rd_rdy(cache_rd_rdy),
    .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type),
    .mem_wr_addr(mem_wr_addr), .mem_wr_wstrb(mem_wr_wstrb),
    .mem_wr_data(mem_wr_data), .mem_wr_rdy(mem_wr_rdy),
    .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type),
    .mem_rd_addr(mem_rd_addr), .mem_rd_rdy(mem_rd_rdy),
    .flush_req(flush_req), .flush_done(flush_done), .wbuf_empty(wbuf_empty)
  );

  typedef struct {
    logic [2:0]   t;
    logic [31:0]  a;
    logic [3:0]   s;
    logic [127:0] d;
  } wr_t;

  typedef struct {
    logic        wr_rdy;
    logic        empty;
    logic        wr_req;
    logic        rd_req;
    logic        rd_rdy;
    logic        done;
    logic [31:0] rd_addr;
    logic [2:0]  rd_type;
  } cyc_t;

  wr_t  model_q[$];
  wr_t  exp_wr_q[$];
  cyc_t exp_cyc_q[$];
  int   mstate = M_RUN;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   end_chk = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: per-cycle output expectations and the ordered write scoreboard.
  always @(negedge clk) begin : mon
    cyc_t c;
    wr_t  w;
    if (exp_cyc_q.size() > 0) begin
      c = exp_cyc_q.pop_front();
      check("cache_wr_rdy", 128'(cache_wr_rdy), 128'(c.wr_rdy));
      check("wbuf_empty",   128'(wbuf_empty),   128'(c.empty));
      check("mem_wr_req",   128'(mem_wr_req),   128'(c.wr_req));
      check("mem_rd_req",   128'(mem_rd_req),   128'(c.rd_req));
      check("cache_rd_rdy", 128'(cache_rd_rdy), 128'(c.rd_rdy));
      check("flush_done",   128'(flush_done),   128'(c.done));
      check("mem_rd_addr",  128'(mem_rd_addr),  128'(c.rd_addr));
      check("mem_rd_type",  128'(mem_rd_type),  128'(c.rd_type));
    end
    if (mem_wr_req === 1'b1 && mem_wr_rdy === 1'b1 && reset === 1'b0) begin
      if (exp_wr_q.size() == 0) begin
        check("unexpected_mem_write", 128'(mem_wr_addr), 128'hffffffff_ffffffff_ffffffff_ffffffff);
      end else begin
        w = exp_wr_q.pop_front();
        check("mem_wr_addr",  128'(mem_wr_addr),  128'(w.a));
        check("mem_wr_type",  128'(mem_wr_type),  128'(w.t));
        check("mem_wr_wstrb", 128'(mem_wr_wstrb), 128'(w.s));
        check("mem_wr_data",  mem_wr_data,        w.d);
      end
    end
    if (end_chk) begin
      check("writes_left_undelivered", 128'(exp_wr_q.size()), 128'(0));
    end
  end

  task automatic set_wr(input logic req, input logic [2:0] ty, input logic [31:0] ad);
    cache_wr_req   = req;
    cache_wr_type  = ty;
    cache_wr_addr  = ad;
    cache_wr_wstrb = 4'($urandom);
    cache_wr_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One clock: predict this cycle's outputs from the model, then advance the model.
  task automatic tick(input bit chk);
    cyc_t c;
    wr_t  w;
    bit   enq, deq, conf;
    int   sz;
    sz       = model_q.size();
    c.wr_rdy = (sz < DEPTH) && (mstate == M_RUN);
    c.empty  = (sz == 0);
    c.wr_req = (sz != 0);
    c.done   = (mstate == M_DONE);
    enq      = cache_wr_req && c.wr_rdy;
    conf     = enq && (cache_wr_addr[31:4] == cache_rd_addr[31:4]);
    foreach (model_q[i]) begin
      if (model_q[i].a[31:4] == cache_rd_addr[31:4]) conf = 1'b1;
    end
    c.rd_req  = cache_rd_req && !conf;
    c.rd_rdy  = mem_rd_rdy && !conf;
    c.rd_addr = cache_rd_addr;
    c.rd_type = cache_rd_type;
    deq       = (sz != 0) && mem_wr_rdy;
    if (chk) exp_cyc_q.push_back(c);
    @(posedge clk);
    if (reset) begin
      model_q.delete();
      exp_wr_q.delete();
      mstate = M_RUN;
    end else begin
      case (mstate)
        M_RUN:   if (flush_req) mstate = M_FLUSH;
        M_FLUSH: if (sz == 0 && !enq) mstate = M_DONE;
        default: mstate = M_RUN;
      endcase
      if (deq) void'(model_q.pop_front());
      if (enq) begin
        w.t = cache_wr_type; w.a = cache_wr_addr; w.s = cache_wr_wstrb; w.d = cache_wr_data;
        model_q.push_back(w);
        exp_wr_q.push_back(w);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    set_wr(1'b0, WR_TYPE_WORD, 32'h0);
    cache_rd_req  = 1'b0;
    cache_rd_type = WR_TYPE_WORD;
    cache_rd_addr = 32'h0;
    mem_rd_rdy    = 1'b0;
    flush_req     = 1'b0;
  endtask

  initial begin
    logic [2:0] ty;
    reset = 1'b1;
    mem_wr_rdy = 1'b0;
    idle_inputs();
    tick(1'b0);
    tick(1'b0);
    reset = 1'b0;
    tick(1'b1);

    // Fill with four lines while the bridge is stalled, then a fifth that must wait.
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, WR_TYPE_LINE, 32'h100 + 32'(i) * 32'h10);
      tick(1'b1);
    end
    set_wr(1'b1, WR_TYPE_LINE, 32'h140);
    tick(1'b1);
    tick(1'b1);
    cache_wr_req = 1'b0;
    mem_wr_rdy = 1'b1;
    repeat (6) tick(1'b1);

    // Read-after-write hazard on a buffered line versus an unrelated line.
    mem_wr_rdy = 1'b0;
    set_wr(1'b1, WR_TYPE_WORD, 32'h1000);
    tick(1'b1);
    cache_wr_req  = 1'b0;
    cache_rd_req  = 1'b1;
    cache_rd_addr = 32'h1008;
    mem_rd_rdy    = 1'b1;
    repeat (3) tick(1'b1);
    cache_rd_addr = 32'h2000;
    tick(1'b1);
    cache_rd_addr = 32'h1008;
    mem_wr_rdy = 1'b1;
    repeat (3) tick(1'b1);
    set_wr(1'b1, WR_TYPE_WORD, 32'h3000);
    cache_rd_addr = 32'h3004;
    tick(1'b1);
    idle_inputs();
    repeat (2) tick(1'b1);

    // Full buffer with simultaneous dequeue, then enq/deq traffic across the wrap.
    mem_wr_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, WR_TYPE_LINE, 32'h200 + 32'(i) * 32'h10);
      tick(1'b1);
    end
    set_wr(1'b1, WR_TYPE_LINE, 32'h240);
    mem_wr_rdy = 1'b1;
    tick(1'b1);
    mem_wr_rdy = 1'b0;
    tick(1'b1);
    mem_wr_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_wr(1'b1, 3'($urandom), 32'h300 + 32'(i) * 32'h10);
      tick(1'b1);
    end
    cache_wr_req = 1'b0;
    repeat (6) tick(1'b1);

    // Flush with two entries pending and writes attempted meanwhile.
    mem_wr_rdy = 1'b0;
    set_wr(1'b1, WR_TYPE_WORD, 32'h500);
    tick(1'b1);
    set_wr(1'b1, WR_TYPE_WORD, 32'h510);
    tick(1'b1);
    set_wr(1'b1, WR_TYPE_WORD, 32'h520);
    flush_req = 1'b1;
    mem_wr_rdy = 1'b1;
    tick(1'b1);
    flush_req = 1'b0;
    repeat (5) tick(1'b1);
    cache_wr_req = 1'b0;
    repeat (3) tick(1'b1);

    // Flush of an already empty buffer.
    flush_req = 1'b1;
    tick(1'b1);
    flush_req = 1'b0;
    repeat (4) tick(1'b1);

    // Reset with three entries buffered.
    mem_wr_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_wr(1'b1, WR_TYPE_LINE, 32'h700 + 32'(i) * 32'h10);
      tick(1'b1);
    end
    cache_wr_req = 1'b0;
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    mem_wr_rdy = 1'b1;
    repeat (4) tick(1'b1);

    // Random traffic over a small set of lines to provoke conflicts.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       ty = WR_TYPE_WORD;
        1:       ty = WR_TYPE_LINE;
        default: ty = 3'($urandom);
      endcase
      set_wr(($urandom_range(0, 99) < 60), ty,
             32'h4000 + (32'($urandom_range(0, 7)) << 4) + 32'($urandom_range(0, 15)));
      cache_rd_req  = ($urandom_range(0, 1) == 1);
      cache_rd_type = 3'($urandom);
      cache_rd_addr = 32'h4000 + (32'($urandom_range(0, 7)) << 4) + 32'($urandom_range(0, 15));
      mem_wr_rdy    = ($urandom_range(0, 1) == 1);
      mem_rd_rdy    = ($urandom_range(0, 9) < 7);
      flush_req     = ($urandom_range(0, 99) < 4);
      reset         = ($urandom_range(0, 199) == 0);
      tick(1'b1);
    end

    reset = 1'b0;
    idle_inputs();
    mem_wr_rdy = 1'b1;
    repeat (8) tick(1'b1);
    end_chk = 1'b1;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_wbuf.md
DCACHE_WBUF -- requirements
Module: dcache_wbuf

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: DEPTH, default 4, number of buffered write entries (power of 2, >=2).
REQ-003 Ports (name dir width meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cache_wr_req  in  1  dcache write request
- cache_wr_type  in  3  010 word, 100 line
- cache_wr_addr  in  32  write address
- cache_wr_wstrb  in  4  byte strobe (word type)
- cache_wr_data  in  128  write data
- cache_wr_rdy  out  1  buffer can accept
- cache_rd_req  in  1  dcache read request
- cache_rd_type  in  3  read type
- cache_rd_addr  in  32  read address
- cache_rd_rdy  out  1  read accepted downstream
- mem_wr_req  out  1  head-entry write to bridge
- mem_wr_type  out  3  head type
- mem_wr_addr  out  32  head address
- mem_wr_wstrb  out  4  head strobe
- mem_wr_data  out  128  head data
- mem_wr_rdy  in  1  bridge write ready
- mem_rd_req  out  1  read request to bridge
- mem_rd_type  out  3  pass-through of cache_rd_type
- mem_rd_addr  out  32  pass-through of cache_rd_addr
- mem_rd_rdy  in  1  bridge read ready
- flush_req  in  1  drain-all request (level)
- flush_done  out  1  one-cycle pulse, buffer drained
- wbuf_empty  out  1  no valid entries

Function
REQ-004 Storage SHALL be a circular FIFO of DEPTH entries {type, addr, wstrb, data}; pointers log2(DEPTH)+1 bits; full when pointer MSBs differ and low bits equal, empty when equal.
REQ-005 cache_wr_rdy SHALL be !full && state==RUN; enqueue on cache_wr_req && cache_wr_rdy.
REQ-006 mem_wr_req SHALL be !empty; mem_wr_* SHALL show head entry; dequeue on mem_wr_req && mem_wr_rdy.
REQ-007 No bypass: enqueue into empty buffer SHALL raise mem_wr_req the next cycle (latency 1).
REQ-008 Simultaneous enqueue and dequeue SHALL leave occupancy unchanged; at full, rdy is low so no enqueue that cycle even if dequeue occurs.
REQ-009 Pointers SHALL wrap modulo DEPTH with MSB toggling; FIFO order strictly preserved.
REQ-010 Read conflict SHALL be asserted when cache_rd_addr[31:4] equals addr[31:4] of any valid entry or of an entry being enqueued in the same cycle.
REQ-011 mem_rd_req SHALL be cache_rd_req && !conflict; cache_rd_rdy SHALL be mem_rd_rdy && !conflict; conflicting reads stall until the matching entry dequeues.
REQ-012 State machine RUN/FLUSH/DONE: RUN->FLUSH on flush_req; FLUSH->DONE when empty and no enqueue pending; DONE->RUN unconditionally after one cycle.
REQ-013 flush_done SHALL be 1 exactly in DONE; flush_req in an already-empty buffer SHALL give flush_done 2 cycles later.
REQ-014 In FLUSH, enqueue refused, draining and non-conflicting reads continue.
REQ-015 wbuf_empty SHALL be combinational from pointers.
REQ-016 Type codes other than 010/100 SHALL be stored and forwarded unchanged.

Reset
REQ-017 Reset SHALL zero both pointers, set state RUN, drive mem_wr_req=0, flush_done=0, wbuf_empty=1, cache_wr_rdy=1 on the cycle after release.
REQ-018 Reset mid-operation SHALL discard all entries; entry data need not be reset.

Structure
REQ-019 Shared package SHALL hold WR_TYPE_WORD=3'b010, WR_TYPE_LINE=3'b100, LINE_OFFSET_BITS=4 and FSM state encodings.
REQ-020 Storage and pointers SHALL live in sub-module wbuf_fifo; conflict compare and FSM in dcache_wbuf.

Verification
REQ-021 Enqueue 4 line writes addr 0x100,0x110,0x120,0x130 with mem_wr_rdy=0 -> cache_wr_rdy=0 after fourth; 5th request stalls.
REQ-022 Then mem_wr_rdy=1 -> mem_wr_addr sequence 0x100,0x110,0x120,0x130 one per cycle, wbuf_empty=1 after last.
REQ-023 Buffered write 0x1000, read 0x1008 -> mem_rd_req=0 until 0x1000 dequeues; read 0x2000 concurrently -> mem_rd_req=1 immediately.
REQ-024 Full buffer, enqueue attempted with simultaneous dequeue -> occupancy 3 then 4 next cycle, no entry lost; 10 enq/deq cycles verify pointer wrap.
REQ-025 Two entries buffered, flush_req=1, mem_wr_rdy=1 -> cache_wr_rdy=0 during FLUSH, flush_done pulses once after second dequeue.
REQ-026 Reset asserted with 3 entries -> next cycle wbuf_empty=1, mem_wr_req=0, no further mem writes.
